fetch_unit: RTL and testbench

Instruction-fetch stage between the program counter and decode. It owns the PC, drives the instruction-memory address, and captures each returned word together with its PC into a small in-order queue. Decode drains the queue through a valid/ready handshake. Branch and jump redirects reset the PC and flush the queue. Instruction memory reads combinationally: `idata` is valid in the same cycle `iaddr` is driven.

---
 rtl/fetch_unit.sv | 74 +++++++
 tb/tb_fetch_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from a combinational instruction
// memory into a small in-order queue, and hands entries to decode via valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  fq_entry_t        r_q [DEPTH];
  logic [31:0]      r_pc;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic             w_fetch;
  logic             w_valid;
  logic             w_deq;
  fq_entry_t        w_head;

  // Fetch only looks at the registered count, so a full queue stalls for a
  // cycle even if decode drains it in the same cycle.
  assign w_fetch = !redirect_valid && (r_count != FULL);
  assign w_valid = (r_count != '0) && !redirect_valid;
  assign w_deq   = w_valid && out_ready;
  assign w_head  = r_q[r_rd_ptr];

  assign iaddr     = r_pc;
  assign out_valid = w_valid;
  assign out_pc    = w_head.pc;
  assign out_instr = w_head.instr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else if (redirect_valid) begin
      r_pc     <= redirect_pc & 32'hFFFF_FFFC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_fetch) begin
        r_q[r_wr_ptr] <= '{pc: r_pc, instr: idata};
        r_wr_ptr      <= r_wr_ptr + AW'(1);
        r_pc          <= r_pc + 32'd4;
      end
      if (w_deq) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_fetch) - CW'(w_deq);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit; memory returns address+1 so every
// delivered word can be tied back to its PC.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .iaddr(iaddr), .idata(idata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr)
  );

  always #5 clk = ~clk;
  assign idata = iaddr + 32'd1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];   // model of queued instructions
  ent_t        exp_q[$]; // scoreboard: instructions decode should receive next
  logic [31:0] mpc;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: pops whenever the DUT completes a handshake.
  always @(negedge clk) begin
    #2;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_deq: got pc %h expected no handshake at %0t", out_pc, $time);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("deq_pc", out_pc, e.pc);
        chk("deq_instr", out_instr, e.instr);
      end
    end
  end

  task automatic model_reset();
    mq.delete();
    mpc = RESET_PC;
  endtask

  // One clock: drive, check visible outputs against the model, advance model.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    bit m_fetch, m_valid, m_deq;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
    m_valid = (mq.size() != 0) && !rv;
    m_fetch = !rv && (mq.size() < DEPTH);
    m_deq   = m_valid && rdy;
    chk("iaddr", iaddr, mpc);
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("head_pc", out_pc, mq[0].pc);
      chk("head_instr", out_instr, mq[0].instr);
    end
    if (m_deq) exp_q.push_back(mq.pop_front());
    if (rv) begin
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
    end else if (m_fetch) begin
      mq.push_back('{pc: mpc, instr: mpc + 32'd1});
      mpc = mpc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_iaddr", iaddr, RESET_PC);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    rst = 1'b1;

    // streaming from reset
    repeat (8) step(1'b1, 1'b0, '0);

    // stall and fill, then drain
    rst = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) step(1'b0, 1'b0, '0);
    chk("stall_iaddr", iaddr, 32'd8);
    repeat (5) step(1'b1, 1'b0, '0);

    // redirect with a full queue
    repeat (3) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h0000_0103);
    repeat (5) step(1'b1, 1'b0, '0);

    // wrap-around
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (5) step(1'b1, 1'b0, '0);

    // redirect during handshake, then back-to-back redirects
    step(1'b1, 1'b1, 32'h0000_0200);
    step(1'b1, 1'b1, 32'h0000_0300);
    repeat (4) step(1'b1, 1'b0, '0);

    // asynchronous reset between edges
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_iaddr", iaddr, RESET_PC);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) step(1'b1, 1'b0, '0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic        r, v;
      logic [31:0] t;
      r = ($urandom_range(0, 9) < 7);
      v = ($urandom_range(0, 14) == 0);
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                      : $urandom;
      step(r, v, t);
    end
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    #3;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
